// File: rtl/task_port_pkg.sv
// task_port_pkg: shared types and default widths for the task port adapter.
//   state_t  : adapter FSM state (IDLE, RECEIVE, DRAIN, ANSWER)
//   CNT_W    : width of the optional input byte counter
//   *_DEF    : default widths/depths, also used by tasks_parameters users
package task_port_pkg;
  localparam int CNT_W         = 12;
  localparam int DIN_W_DEF     = 8;
  localparam int DOUT_W_DEF    = 32;
  localparam int IN_DEPTH_DEF  = 16;
  localparam int OUT_DEPTH_DEF = 16;
  localparam int SKID_DEF      = 6;
  localparam int EXP_BYTES_DEF = 64;

  typedef enum logic [1:0] {IDLE, RECEIVE, DRAIN, ANSWER} state_t;
endpackage

// File: rtl/task_port_fifo.sv
// task_port_fifo: first-word fall-through synchronous FIFO.
//   clk, rst_n      : clock, async active-low reset (pointers/count/flag only)
//   push, din       : write request and data
//   pop             : read request; ignored when empty
//   dout            : head entry, valid whenever !empty
//   full, empty     : occupancy flags
//   count           : number of stored entries
//   overflow        : sticky, set when a push is dropped because the FIFO is full
module task_port_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             pop_ok, push_ok;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign pop_ok  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push on full is still taken.
  assign push_ok = push && (!full || pop_ok);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk)
    if (push_ok) mem[wr_ptr] <= din;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
      if (push && !push_ok) overflow <= 1'b1;
    end
  end
endmodule

// File: rtl/task_port_adapter.sv
// task_port_adapter: task-side endpoint of the manager in/out links.
//   Buffers manager bytes (tim_*) into an input FIFO feeding the core (core_din*),
//   buffers core results (core_dout*) into an output FIFO streamed back as
//   answer words (tom_*), with last-word marking.
//   i_clk, i_rst_n : clock, async active-low reset (aborts any run)
//   tim_*          : byte stream from manager, tim_data_request back-pressure
//   tom_*          : answer word stream to manager
//   core_*         : byte stream to core / result stream from core
//   busy           : state != IDLE
//   byte_err       : input byte-count mismatch (TASK_PORT_BYTE_CHECK_EN only, else 0)
//   dbg_overflow   : sticky FIFO overflow, debug visibility only
// Build option: define TASK_PORT_BYTE_CHECK_EN to build the input byte counter.
module task_port_adapter
  import task_port_pkg::*;
#(
  parameter int DIN_WIDTH  = DIN_W_DEF,
  parameter int DOUT_WIDTH = DOUT_W_DEF,
  parameter int IN_DEPTH   = IN_DEPTH_DEF,
  parameter int OUT_DEPTH  = OUT_DEPTH_DEF,
  parameter int SKID       = SKID_DEF,
  parameter int EXP_BYTES  = EXP_BYTES_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  tim_data_valid,
  input  logic [DIN_WIDTH-1:0]  tim_data,
  input  logic                  tim_data_last,
  output logic                  tim_data_request,
  output logic                  tom_answer_ready,
  output logic [DOUT_WIDTH-1:0] tom_answer_data,
  output logic                  tom_answer_last,
  input  logic                  tom_manager_ready,
  output logic [DIN_WIDTH-1:0]  core_din,
  output logic                  core_din_valid,
  output logic                  core_din_last,
  input  logic                  core_din_ready,
  input  logic [DOUT_WIDTH-1:0] core_dout,
  input  logic                  core_dout_valid,
  input  logic                  core_dout_last,
  output logic                  core_dout_ready,
  output logic                  busy,
  output logic                  byte_err,
  output logic                  dbg_overflow
);
  localparam int IAW = $clog2(IN_DEPTH);
  localparam int OAW = $clog2(OUT_DEPTH);

  state_t            state, state_nxt;
  logic              in_full, in_empty, in_pop, in_push_ok, in_ovf;
  logic [IAW:0]      in_cnt, in_cnt_nxt;
  logic [DIN_WIDTH:0]  in_head;
  logic              out_full, out_empty, out_push, out_pop, out_ovf;
  logic [OAW:0]      out_cnt;
  logic [DOUT_WIDTH:0] out_head;

  assign in_pop     = !in_empty && core_din_ready;
  assign in_push_ok = tim_data_valid && (!in_full || in_pop);
  assign in_cnt_nxt = in_cnt + (IAW+1)'(in_push_ok) - (IAW+1)'(in_pop);
  assign out_push   = core_dout_valid && core_dout_ready;
  assign out_pop    = tom_manager_ready && tom_answer_ready;
  assign dbg_overflow = in_ovf | out_ovf;

  task_port_fifo #(.WIDTH(DIN_WIDTH+1), .DEPTH(IN_DEPTH)) u_in_fifo (
    .clk(i_clk), .rst_n(i_rst_n),
    .push(tim_data_valid), .din({tim_data_last, tim_data}), .pop(in_pop),
    .dout(in_head), .full(in_full), .empty(in_empty), .count(in_cnt),
    .overflow(in_ovf)
  );

  task_port_fifo #(.WIDTH(DOUT_WIDTH+1), .DEPTH(OUT_DEPTH)) u_out_fifo (
    .clk(i_clk), .rst_n(i_rst_n),
    .push(out_push), .din({core_dout_last, core_dout}), .pop(out_pop),
    .dout(out_head), .full(out_full), .empty(out_empty), .count(out_cnt),
    .overflow(out_ovf)
  );

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (tim_data_valid) state_nxt = tim_data_last ? DRAIN : RECEIVE;
      RECEIVE: if (tim_data_valid && tim_data_last) state_nxt = DRAIN;
      DRAIN:   if (out_push && core_dout_last) state_nxt = ANSWER;
      ANSWER:  if (out_pop && out_head[DOUT_WIDTH]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FIFO heads are gated so outputs read 0 whenever nothing valid is presented.
  always_comb begin
    busy             = (state != IDLE);
    core_dout_ready  = (state == DRAIN) && !out_full;
    tom_answer_ready = (state == ANSWER) && !out_empty;
    tom_answer_data  = tom_answer_ready ? out_head[DOUT_WIDTH-1:0] : '0;
    tom_answer_last  = tom_answer_ready && out_head[DOUT_WIDTH];
    core_din_valid   = !in_empty;
    core_din         = core_din_valid ? in_head[DIN_WIDTH-1:0] : '0;
    core_din_last    = core_din_valid && in_head[DIN_WIDTH];
  end

  // Request looks at next-cycle occupancy so that, once it drops, SKID more
  // in-flight bytes still fit without loss.
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) tim_data_request <= 1'b0;
    else tim_data_request <= (state_nxt == IDLE || state_nxt == RECEIVE) &&
                             (in_cnt_nxt < (IAW+1)'(IN_DEPTH - SKID));

`ifdef TASK_PORT_BYTE_CHECK_EN
  logic [CNT_W-1:0] byte_cnt;

  // First byte of a run restarts the count and clears any previous error.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      byte_cnt <= '0;
      byte_err <= 1'b0;
    end else if (state == IDLE && tim_data_valid) begin
      byte_cnt <= CNT_W'(1);
      byte_err <= tim_data_last && (EXP_BYTES != 1);
    end else if (in_push_ok) begin
      byte_cnt <= byte_cnt + CNT_W'(1);
      if (tim_data_last) byte_err <= (byte_cnt + CNT_W'(1)) != CNT_W'(EXP_BYTES);
    end
  end
`else
  assign byte_err = 1'b0;
`endif
endmodule

// File: tb/tb_task_port_adapter.sv
module tb_task_port_adapter;
  logic        clk = 1'b0;
  logic        i_rst_n;
  logic        tim_data_valid, tim_data_last, tim_data_request;
  logic [7:0]  tim_data;
  logic        tom_answer_ready, tom_answer_last, tom_manager_ready;
  logic [31:0] tom_answer_data;
  logic [7:0]  core_din;
  logic        core_din_valid, core_din_last, core_din_ready;
  logic [31:0] core_dout;
  logic        core_dout_valid, core_dout_last, core_dout_ready;
  logic        busy, byte_err, dbg_overflow;

  int checks = 0;
  int passes = 0;

`ifdef TASK_PORT_BYTE_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  task_port_adapter dut (
    .i_clk(clk), .i_rst_n(i_rst_n),
    .tim_data_valid(tim_data_valid), .tim_data(tim_data), .tim_data_last(tim_data_last),
    .tim_data_request(tim_data_request),
    .tom_answer_ready(tom_answer_ready), .tom_answer_data(tom_answer_data),
    .tom_answer_last(tom_answer_last), .tom_manager_ready(tom_manager_ready),
    .core_din(core_din), .core_din_valid(core_din_valid), .core_din_last(core_din_last),
    .core_din_ready(core_din_ready),
    .core_dout(core_dout), .core_dout_valid(core_dout_valid), .core_dout_last(core_dout_last),
    .core_dout_ready(core_dout_ready),
    .busy(busy), .byte_err(byte_err), .dbg_overflow(dbg_overflow)
  );

  always #5 clk = ~clk;

  task step;
    @(posedge clk); #1;
  endtask

  task test_reset;
    logic [47:0] outs;
    i_rst_n = 1'b0;
    tim_data_valid = 0; tim_data = '0; tim_data_last = 0; tom_manager_ready = 0;
    core_din_ready = 0; core_dout = '0; core_dout_valid = 0; core_dout_last = 0;
    step; step;
    outs = {tim_data_request, tom_answer_ready, tom_answer_data, tom_answer_last, core_din,
            core_din_valid, core_din_last, core_dout_ready, busy, byte_err, dbg_overflow};
    checks++; if (outs !== '0) $display("FAIL reset_outs: got %h want 0", outs); else passes++;
    i_rst_n = 1'b1;
    checks++; if (tim_data_request !== 1'b0) $display("FAIL reset_req_hold: got %b want 0", tim_data_request); else passes++;
    step;
    checks++; if (tim_data_request !== 1'b1) $display("FAIL reset_req_rise: got %b want 1", tim_data_request); else passes++;
  endtask

  task test_stream;
    core_din_ready = 1;
    for (int i = 0; i < 64; i++) begin
      tim_data_valid = 1; tim_data = 8'(i); tim_data_last = (i == 63);
      step;
      checks++;
      if (core_din_valid !== 1'b1 || core_din !== 8'(i) || core_din_last !== (i == 63))
        $display("FAIL stream_byte%0d: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                 i, core_din_valid, core_din, core_din_last, 8'(i), (i == 63));
      else passes++;
    end
    tim_data_valid = 0; tim_data_last = 0;
    checks++; if (core_dout_ready !== 1'b1 || busy !== 1'b1) $display("FAIL stream_drain: got rdy=%b busy=%b want 1 1", core_dout_ready, busy); else passes++;
    checks++; if (tim_data_request !== 1'b0) $display("FAIL stream_req: got %b want 0", tim_data_request); else passes++;
    checks++; if (byte_err !== 1'b0) $display("FAIL stream_err: got %b want 0", byte_err); else passes++;
    step;
    checks++; if (core_din_valid !== 1'b0) $display("FAIL stream_empty: got %b want 0", core_din_valid); else passes++;
  endtask

  task test_answer;
    tom_manager_ready = 1;
    core_dout_valid = 1; core_dout = 32'hDEADBEEF; core_dout_last = 0;
    step;
    checks++; if (tom_answer_ready !== 1'b0) $display("FAIL ans_not_ready_drain: got %b want 0", tom_answer_ready); else passes++;
    core_dout = 32'h12345678; core_dout_last = 1;
    step;
    core_dout_valid = 0; core_dout_last = 0;
    checks++; if (tom_answer_ready !== 1'b1 || tom_answer_data !== 32'hDEADBEEF || tom_answer_last !== 1'b0)
      $display("FAIL ans_word0: got r=%b d=%h l=%b want 1 deadbeef 0", tom_answer_ready, tom_answer_data, tom_answer_last);
    else passes++;
    step;
    checks++; if (tom_answer_ready !== 1'b1 || tom_answer_data !== 32'h12345678 || tom_answer_last !== 1'b1)
      $display("FAIL ans_word1: got r=%b d=%h l=%b want 1 12345678 1", tom_answer_ready, tom_answer_data, tom_answer_last);
    else passes++;
    tom_manager_ready = 0;
    step;
    checks++; if (tom_answer_ready !== 1'b1 || tom_answer_data !== 32'h12345678)
      $display("FAIL ans_hold: got r=%b d=%h want 1 12345678", tom_answer_ready, tom_answer_data);
    else passes++;
    tom_manager_ready = 1;
    step;
    tom_manager_ready = 0;
    checks++; if (tom_answer_ready !== 1'b0 || busy !== 1'b0) $display("FAIL ans_idle: got r=%b busy=%b want 0 0", tom_answer_ready, busy); else passes++;
    checks++; if (tim_data_request !== 1'b1) $display("FAIL ans_req: got %b want 1", tim_data_request); else passes++;
  endtask

  task test_backpressure;
    int sent;
    sent = 0;
    core_din_ready = 0;
    for (int k = 0; k < 20; k++) begin
      if (!tim_data_request) break;
      tim_data_valid = 1; tim_data = 8'(8'h80 + sent); tim_data_last = 0;
      sent++;
      step;
    end
    checks++; if (sent !== 10) $display("FAIL bp_req_fall: got %0d bytes before drop want 10", sent); else passes++;
    for (int j = 0; j < 6; j++) begin
      tim_data = 8'(8'h80 + sent); sent++;
      step;
    end
    tim_data_valid = 0;
    checks++; if (dbg_overflow !== 1'b0 || tim_data_request !== 1'b0)
      $display("FAIL bp_skid: got ovf=%b req=%b want 0 0", dbg_overflow, tim_data_request);
    else passes++;
    core_din_ready = 1;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (core_din_valid !== 1'b1 || core_din !== 8'(8'h80 + i) || core_din_last !== 1'b0)
        $display("FAIL bp_byte%0d: got v=%b d=%h l=%b want 1 %h 0", i, core_din_valid, core_din, core_din_last, 8'(8'h80 + i));
      else passes++;
      step;
    end
    checks++; if (core_din_valid !== 1'b0 || tim_data_request !== 1'b1)
      $display("FAIL bp_drained: got v=%b req=%b want 0 1", core_din_valid, tim_data_request);
    else passes++;
    tim_data_valid = 1; tim_data = 8'hFF; tim_data_last = 1;
    step;
    tim_data_valid = 0; tim_data_last = 0;
    checks++; if (core_din !== 8'hFF || core_din_last !== 1'b1 || core_dout_ready !== 1'b1)
      $display("FAIL bp_last: got d=%h l=%b cdr=%b want ff 1 1", core_din, core_din_last, core_dout_ready);
    else passes++;
    step;
  endtask

  task test_reset_mid_answer;
    logic [31:0] w [3];
    w[0] = 32'h11111111; w[1] = 32'h22222222; w[2] = 32'h33333333;
    tom_manager_ready = 0;
    for (int i = 0; i < 3; i++) begin
      core_dout_valid = 1; core_dout = w[i]; core_dout_last = (i == 2);
      step;
    end
    core_dout_valid = 0; core_dout_last = 0;
    checks++; if (tom_answer_ready !== 1'b1 || tom_answer_data !== 32'h11111111)
      $display("FAIL rst_mid_pre: got r=%b d=%h want 1 11111111", tom_answer_ready, tom_answer_data);
    else passes++;
    i_rst_n = 0;
    #1;
    checks++; if (tom_answer_ready !== 1'b0 || tom_answer_data !== 32'h0 || busy !== 1'b0 || core_dout_ready !== 1'b0)
      $display("FAIL rst_mid_abort: got r=%b d=%h busy=%b cdr=%b want 0 0 0 0", tom_answer_ready, tom_answer_data, busy, core_dout_ready);
    else passes++;
    step;
    i_rst_n = 1;
    step;
    checks++; if (tim_data_request !== 1'b1 || core_din_valid !== 1'b0 || tom_answer_ready !== 1'b0 || busy !== 1'b0)
      $display("FAIL rst_mid_after: got req=%b cv=%b r=%b busy=%b want 1 0 0 0", tim_data_request, core_din_valid, tom_answer_ready, busy);
    else passes++;
  endtask

  task test_byte_check;
    core_din_ready = 1;
    for (int i = 0; i < 63; i++) begin
      tim_data_valid = 1; tim_data = 8'(i); tim_data_last = (i == 62);
      step;
    end
    tim_data_valid = 0; tim_data_last = 0;
    checks++; if (byte_err !== CHK) $display("FAIL bc_short: got %b want %b", byte_err, CHK); else passes++;
    step;
    core_dout_valid = 1; core_dout = 32'h1; core_dout_last = 1;
    step;
    core_dout_valid = 0; core_dout_last = 0;
    tom_manager_ready = 1;
    step;
    tom_manager_ready = 0;
    checks++; if (busy !== 1'b0 || byte_err !== CHK) $display("FAIL bc_sticky: got busy=%b err=%b want 0 %b", busy, byte_err, CHK); else passes++;
    for (int i = 0; i < 64; i++) begin
      tim_data_valid = 1; tim_data = 8'(i); tim_data_last = (i == 63);
      step;
      if (i == 0) begin
        checks++; if (byte_err !== 1'b0) $display("FAIL bc_clear: got %b want 0", byte_err); else passes++;
      end
    end
    tim_data_valid = 0; tim_data_last = 0;
    checks++; if (byte_err !== 1'b0) $display("FAIL bc_full_run: got %b want 0", byte_err); else passes++;
  endtask

  initial begin
    test_reset;
    test_stream;
    test_answer;
    test_backpressure;
    test_reset_mid_answer;
    test_byte_check;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
